aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Upstream feeder for the AES encrypt/decrypt stage. Drains 16-bit words from the SDRAM read-FIFO port, packs eight consecutive words into one 128-bit block (word 0 in bits [15:0]), and hands each block to the AES stage over a valid/ready handshake. Runs for a programmed number of blocks per start pulse, then reports done. This replaces the word-gathering loop inside the AES test controller with a reusable, back-pressured stage.

## Interface
Parameters:
- DATA_W, 16, FIFO word width
- BLOCK_W, 128, block width; must equal 8*DATA_W
- LVL_W, 16, width of FIFO used-word count
- CNT_W, 16, width of block counters
- RD_LAT, 2, cycles from oREAD high to valid iREADDATA (≥1)

Ports:
- iCLK  in  1  sole clock
- iRST  in  1  reset, synchronous, active-high
- iSTART  in  1  one-cycle start pulse
- iBLOCKS  in  CNT_W  blocks to pack this run; latched on accepted iSTART
- iFIFO_USED  in  LVL_W  words available in read FIFO
- iFIFO_BUSY  in  1  SDRAM controller refilling FIFO; no read may issue
- oREAD  out  1  one-cycle FIFO read strobe
- iREADDATA  in  DATA_W  FIFO data, valid RD_LAT cycles after oREAD
- oBLOCK  out  BLOCK_W  packed block
- oBLOCK_VALID  out  1  oBLOCK holds a complete block
- iBLOCK_READY  in  1  AES stage accepts block
- oBUSY  out  1  run in progress
- oDONE  out  1  run complete; sticky until next accepted iSTART
- oWORD_IDX  out  3  next word slot to fill
- oBLOCK_COUNT  out  CNT_W  blocks handed off this run

## Operation
- States: IDLE, WAIT_DATA, LATCH, PRESENT, DONE.
- IDLE/DONE: iSTART accepted → latch iBLOCKS, clear oBLOCK, oWORD_IDX, oBLOCK_COUNT, oDONE; if iBLOCKS==0 → DONE, else → WAIT_DATA. iSTART in any other state ignored.
- WAIT_DATA: if iFIFO_USED!=0 and !iFIFO_BUSY → register oREAD=1, → LATCH; else hold.
- LATCH: internal counter from 0; on RD_LAT-th edge after oREAD high, write iREADDATA into oBLOCK[16*idx+15:16*idx]. If idx==7 → idx=0, → PRESENT; else idx+1, → WAIT_DATA.
- PRESENT: oBLOCK_VALID=1, oBLOCK frozen. On iBLOCK_READY: oBLOCK_COUNT+1; if new count==latched iBLOCKS → DONE, else → WAIT_DATA (oBLOCK not cleared; slots overwritten).
- DONE: oDONE=1, oBUSY=0.
- oBUSY=1 in WAIT_DATA, LATCH, PRESENT.
- Counters wrap never: run ends at equality; oBLOCK_COUNT width CNT_W, iBLOCKS up to 2^CNT_W−1.

## Timing
- Reset (any state, mid-word or mid-handshake): state IDLE, oREAD=0, oBLOCK=0, oBLOCK_VALID=0, oBUSY=0, oDONE=0, oWORD_IDX=0, oBLOCK_COUNT=0. Outstanding FIFO read data discarded.
- oREAD high exactly one cycle per word; never two reads outstanding.
- oREAD high in cycle T → iREADDATA sampled at end of cycle T+RD_LAT → earliest next oREAD in cycle T+RD_LAT+2. Per word RD_LAT+2 cycles (4 at default); block min 8*(RD_LAT+2)+1 cycles incl. handshake.
- iFIFO_BUSY/iFIFO_USED sampled only in WAIT_DATA; changes during LATCH have no effect.
- oBLOCK_VALID rises cycle after 8th word captured; stays high until the edge where iBLOCK_READY=1; ready high in the same cycle valid rises counts as handshake.
- iBLOCK_READY outside PRESENT ignored.
- iSTART same cycle as iRST: reset wins.

## Structure
- Shared package aes_stream_pkg: state encoding, WORDS_PER_BLOCK=BLOCK_W/DATA_W, DATA_W/BLOCK_W defaults (also used by the AES stage and the write-back serializer).
- Single flat module; no sub-module warranted.

## Test plan
- Start with iBLOCKS=1, FIFO words 0x0001..0x0008, iBLOCK_READY=1 → oBLOCK=0x0008_0007_…_0001, valid one cycle, oDONE=1, oBLOCK_COUNT=1, exactly 8 oREAD pulses 4 cycles apart.
- iBLOCKS=3, ready held low 10 cycles per block → oBLOCK stable while valid, no oREAD during PRESENT, oBLOCK_COUNT 0→3, then DONE.
- iFIFO_USED=0 for 20 cycles, then 8; iFIFO_BUSY pulsed mid-block → no oREAD while empty/busy; data intact.
- iBLOCKS=0 → DONE next cycle, zero oREAD.
- iRST asserted in LATCH after word 5 → all outputs reset values next cycle; restart packs fresh block from word 0.
- iSTART pulsed while busy → ignored, original iBLOCKS honoured.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Types and constants shared by the AES streaming stages: the block packer,
// the AES engine and the write-back serializer.
package aes_stream_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int BLOCK_W_DEF     = 128;
    localparam int WORDS_PER_BLOCK = BLOCK_W_DEF / DATA_W_DEF;
    localparam int IDX_W           = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_LATCH     = 3'd2,
        ST_PRESENT   = 3'd3,
        ST_DONE      = 3'd4
    } pack_state_e;

    function automatic logic is_busy_state(input pack_state_e st);
        logic busy;
        case (st)
            ST_WAIT_DATA, ST_LATCH, ST_PRESENT: busy = 1'b1;
            default:                            busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Gathers FIFO words into 128-bit blocks and hands them to the AES stage
// over valid/ready, for a programmed number of blocks per start pulse.
module aes_block_packer
    import aes_stream_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int LVL_W   = 16,
    parameter int CNT_W   = 16,
    parameter int RD_LAT  = 2
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic [CNT_W-1:0]   iBLOCKS,
    input  logic [LVL_W-1:0]   iFIFO_USED,
    input  logic               iFIFO_BUSY,
    output logic               oREAD,
    input  logic [DATA_W-1:0]  iREADDATA,
    output logic [BLOCK_W-1:0] oBLOCK,
    output logic               oBLOCK_VALID,
    input  logic               iBLOCK_READY,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [2:0]         oWORD_IDX,
    output logic [CNT_W-1:0]   oBLOCK_COUNT
);

    localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);

    pack_state_e        state_r, state_s;
    logic               read_r, read_s;
    logic [BLOCK_W-1:0] block_r, block_s;
    logic               valid_r, valid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [CNT_W-1:0]   blocks_r, blocks_s;
    logic [LAT_W-1:0]   lat_r, lat_s;
    logic [CNT_W-1:0]   count_inc_s;

    // Next-state and next-output decode for the packing sequence
    always_comb begin
        state_s     = state_r;
        read_s      = 1'b0;
        block_s     = block_r;
        valid_s     = valid_r;
        idx_s       = idx_r;
        count_s     = count_r;
        blocks_s    = blocks_r;
        lat_s       = lat_r;
        count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (iSTART) begin
                    blocks_s = iBLOCKS;
                    block_s  = {BLOCK_W{1'b0}};
                    idx_s    = {IDX_W{1'b0}};
                    count_s  = {CNT_W{1'b0}};
                    valid_s  = 1'b0;
                    state_s  = (iBLOCKS == {CNT_W{1'b0}}) ? ST_DONE : ST_WAIT_DATA;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_DATA: begin
                // FIFO status is only looked at here; LATCH ignores it
                if ((iFIFO_USED != {LVL_W{1'b0}}) && !iFIFO_BUSY) begin
                    read_s  = 1'b1;
                    lat_s   = {LAT_W{1'b0}};
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_LATCH: begin
                if (lat_r == LAT_LAST) begin
                    block_s[int'(idx_r)*DATA_W +: DATA_W] = iREADDATA;
                    if (idx_r == LAST_IDX) begin
                        idx_s   = {IDX_W{1'b0}};
                        valid_s = 1'b1;
                        state_s = ST_PRESENT;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_WAIT_DATA;
                    end
                end else begin
                    lat_s = lat_r + {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PRESENT: begin
                if (iBLOCK_READY) begin
                    count_s = count_inc_s;
                    valid_s = 1'b0;
                    state_s = (count_inc_s == blocks_r) ? ST_DONE : ST_WAIT_DATA;
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = is_busy_state(state_s);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers; reset drops any read still in flight
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r  <= ST_IDLE;
            read_r   <= 1'b0;
            block_r  <= {BLOCK_W{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            blocks_r <= {CNT_W{1'b0}};
            lat_r    <= {LAT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            read_r   <= read_s;
            block_r  <= block_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            idx_r    <= idx_s;
            count_r  <= count_s;
            blocks_r <= blocks_s;
            lat_r    <= lat_s;
        end
    end

    assign oREAD        = read_r;
    assign oBLOCK       = block_r;
    assign oBLOCK_VALID = valid_r;
    assign oBUSY        = busy_r;
    assign oDONE        = done_r;
    assign oWORD_IDX    = idx_r;
    assign oBLOCK_COUNT = count_r;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: a FIFO model feeds words with the
// programmed read latency and expected blocks are popped at each handshake.
module tb_aes_block_packer;

    localparam int DATA_W  = 16;
    localparam int BLOCK_W = 128;
    localparam int LVL_W   = 16;
    localparam int CNT_W   = 16;
    localparam int RD_LAT  = 2;

    logic               iCLK = 1'b0;
    logic               iRST;
    logic               iSTART;
    logic [CNT_W-1:0]   iBLOCKS;
    logic [LVL_W-1:0]   iFIFO_USED;
    logic               iFIFO_BUSY;
    logic               oREAD;
    logic [DATA_W-1:0]  iREADDATA;
    logic [BLOCK_W-1:0] oBLOCK;
    logic               oBLOCK_VALID;
    logic               iBLOCK_READY;
    logic               oBUSY;
    logic               oDONE;
    logic [2:0]         oWORD_IDX;
    logic [CNT_W-1:0]   oBLOCK_COUNT;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0]  word_q[$];
    logic [BLOCK_W-1:0] exp_q[$];
    int                 rd_log[$];
    int                 cyc = 0;
    int                 rd_total = 0;
    int                 hs_total = 0;
    int                 valid_cycles = 0;
    int                 exp_count = 0;

    aes_block_packer #(
        .DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .LVL_W(LVL_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBLOCKS(iBLOCKS),
        .iFIFO_USED(iFIFO_USED), .iFIFO_BUSY(iFIFO_BUSY), .oREAD(oREAD),
        .iREADDATA(iREADDATA), .oBLOCK(oBLOCK), .oBLOCK_VALID(oBLOCK_VALID),
        .iBLOCK_READY(iBLOCK_READY), .oBUSY(oBUSY), .oDONE(oDONE),
        .oWORD_IDX(oWORD_IDX), .oBLOCK_COUNT(oBLOCK_COUNT)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model, read-protocol checks and handshake scoreboard
    logic              pend_v = 1'b0;
    int                pend_cyc = 0;
    logic [DATA_W-1:0] pend_d = '0;
    logic              fifo_ok_last = 1'b0;
    logic              prev_valid = 1'b0;
    logic [BLOCK_W-1:0] prev_blk = '0;
    logic              have_last_rd = 1'b0;
    int                last_rd = 0;

    always @(negedge iCLK) begin
        if (iRST) begin
            pend_v       = 1'b0;
            exp_count    = 0;
            word_q.delete();
            exp_q.delete();
            fifo_ok_last = 1'b0;
            prev_valid   = 1'b0;
            have_last_rd = 1'b0;
            iREADDATA    = 16'hDEAD;
        end else begin
            if (oREAD) begin
                rd_total++;
                rd_log.push_back(cyc);
                check_eq("rd_fifo_ok", fifo_ok_last, 1'b1);
                check_eq("rd_one_outstanding", pend_v, 1'b0);
                check_eq("rd_fifo_has_word", (word_q.size() != 0), 1'b1);
                if (have_last_rd) check_eq("rd_gap_min", (cyc - last_rd >= RD_LAT + 2), 1'b1);
                have_last_rd = 1'b1;
                last_rd      = cyc;
                pend_d       = (word_q.size() != 0) ? word_q.pop_front() : 16'hBAD0;
                pend_v       = 1'b1;
                pend_cyc     = cyc + RD_LAT;
            end
            if (pend_v && (cyc == pend_cyc)) begin
                iREADDATA = pend_d;
                pend_v    = 1'b0;
            end else begin
                iREADDATA = 16'hDEAD;
            end
            if (oBLOCK_VALID) begin
                valid_cycles++;
                check_eq("no_rd_in_present", oREAD, 1'b0);
                if (prev_valid) check_eq("blk_stable", oBLOCK, prev_blk);
            end
            if (oBUSY) check_eq("blk_count", oBLOCK_COUNT, exp_count);
            if (oBLOCK_VALID && iBLOCK_READY) begin
                hs_total++;
                check_eq("hs_pending_exp", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) check_eq("blk_data", oBLOCK, exp_q.pop_front());
                exp_count++;
            end
            if (iSTART && !oBUSY) exp_count = 0;
            prev_valid   = oBLOCK_VALID;
            prev_blk     = oBLOCK;
            fifo_ok_last = (iFIFO_USED != '0) && !iFIFO_BUSY;
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push_block(input logic [DATA_W-1:0] base);
        logic [BLOCK_W-1:0] blk;
        logic [DATA_W-1:0]  w;
        blk = '0;
        for (int i = 0; i < 8; i++) begin
            w = base + DATA_W'(i);
            word_q.push_back(w);
            blk[i*DATA_W +: DATA_W] = w;
        end
        exp_q.push_back(blk);
    endtask

    task automatic pulse_start(input int n);
        iBLOCKS = CNT_W'(n);
        iSTART  = 1'b1;
        tick();
        iSTART  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !oDONE; i++) tick();
        check_eq(tag, oDONE, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !oBLOCK_VALID; i++) tick();
        check_eq(tag, oBLOCK_VALID, 1'b1);
    endtask

    task automatic wait_reads(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && rd_total < target; i++) tick();
        check_eq(tag, rd_total, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read"},  oREAD, 1'b0);
        check_eq({tag, "_block"}, oBLOCK, '0);
        check_eq({tag, "_valid"}, oBLOCK_VALID, 1'b0);
        check_eq({tag, "_busy"},  oBUSY, 1'b0);
        check_eq({tag, "_done"},  oDONE, 1'b0);
        check_eq({tag, "_idx"},   oWORD_IDX, 3'd0);
        check_eq({tag, "_count"}, oBLOCK_COUNT, '0);
    endtask

    initial begin
        int r0, h0, v0;
        iRST = 1'b1; iSTART = 1'b0; iBLOCKS = '0; iFIFO_USED = 16'd8;
        iFIFO_BUSY = 1'b0; iBLOCK_READY = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        iRST = 1'b0;
        tick();

        // One block, ready held high
        iBLOCK_READY = 1'b1;
        push_block(16'h0001);
        r0 = rd_total; h0 = hs_total; v0 = valid_cycles;
        pulse_start(1);
        wait_done("t1_done", 400);
        check_eq("t1_block", oBLOCK, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check_eq("t1_busy", oBUSY, 1'b0);
        check_eq("t1_count", oBLOCK_COUNT, 16'd1);
        check_eq("t1_reads", rd_total - r0, 8);
        check_eq("t1_valid_cycles", valid_cycles - v0, 1);
        check_eq("t1_handshakes", hs_total - h0, 1);
        for (int i = 1; i < 8; i++) check_eq("t1_rd_gap", rd_log[r0+i] - rd_log[r0+i-1], 4);

        // Three blocks with back-pressure
        iBLOCK_READY = 1'b0;
        push_block(16'h1000); push_block(16'h2000); push_block(16'h3000);
        h0 = hs_total;
        pulse_start(3);
        for (int b = 0; b < 3; b++) begin
            wait_valid("t2_valid", 200);
            repeat (10) tick();
            check_eq("t2_valid_held", oBLOCK_VALID, 1'b1);
            iBLOCK_READY = 1'b1;
            tick();
            iBLOCK_READY = 1'b0;
        end
        wait_done("t2_done", 50);
        check_eq("t2_count", oBLOCK_COUNT, 16'd3);
        check_eq("t2_handshakes", hs_total - h0, 3);

        // Empty FIFO, then busy pulse mid-block
        iBLOCK_READY = 1'b1;
        iFIFO_USED = 16'd0;
        push_block(16'hA5A0);
        r0 = rd_total;
        pulse_start(1);
        repeat (20) tick();
        check_eq("t3_no_rd_empty", rd_total, r0);
        check_eq("t3_busy_waiting", oBUSY, 1'b1);
        iFIFO_USED = 16'd8;
        wait_reads("t3_reads3", r0 + 3, 100);
        iFIFO_BUSY = 1'b1;
        repeat (6) tick();
        check_eq("t3_no_rd_busy", rd_total, r0 + 3);
        iFIFO_BUSY = 1'b0;
        wait_done("t3_done", 200);
        check_eq("t3_block", oBLOCK, 128'hA5A7_A5A6_A5A5_A5A4_A5A3_A5A2_A5A1_A5A0);

        // Zero-block run
        r0 = rd_total;
        pulse_start(0);
        check_eq("t4_done", oDONE, 1'b1);
        check_eq("t4_busy", oBUSY, 1'b0);
        check_eq("t4_block_cleared", oBLOCK, '0);
        repeat (5) tick();
        check_eq("t4_no_reads", rd_total, r0);
        check_eq("t4_count", oBLOCK_COUNT, 16'd0);

        // Reset in LATCH of the sixth word, then a fresh run
        push_block(16'h0100);
        r0 = rd_total;
        pulse_start(1);
        wait_reads("t5_reads6", r0 + 6, 200);
        check_eq("t5_idx_before_rst", oWORD_IDX, 3'd5);
        iRST = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        iRST = 1'b0;
        tick();
        push_block(16'h0200);
        h0 = hs_total;
        pulse_start(1);
        wait_done("t5_done", 400);
        check_eq("t5_block", oBLOCK, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
        check_eq("t5_handshakes", hs_total - h0, 1);

        // Start while busy is ignored
        push_block(16'h3300); push_block(16'h4400);
        r0 = rd_total; h0 = hs_total;
        pulse_start(2);
        wait_reads("t6_reads3", r0 + 3, 100);
        pulse_start(5);
        wait_done("t6_done", 600);
        check_eq("t6_count", oBLOCK_COUNT, 16'd2);
        check_eq("t6_handshakes", hs_total - h0, 2);
        repeat (10) tick();
        check_eq("t6_reads", rd_total - r0, 16);
        check_eq("t6_done_sticky", oDONE, 1'b1);
        check_eq("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
